// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and counter-width helper for alu_param.
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_OR     = 3'b100;
    localparam logic [2:0] OP_XOR    = 3'b101;
    localparam logic [2:0] OP_DIV    = 3'b110;
    localparam logic [2:0] OP_PASS_A = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_param_if.sv
// Operand/result bus of alu_param: master drives operands and Init, slave returns results.
interface alu_param_if #(parameter int WIDTH = 4);

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         select;
    logic               init;
    logic [2*WIDTH-1:0] sal;
    logic               cout;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output a, b, select, init,
        input  sal, cout, busy, done, err
    );

    modport slave (
        input  a, b, select, init,
        output sal, cout, busy, done, err
    );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator and shift register.
// The divide path and its mode input exist only when ALU_DIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
`ifdef ALU_DIV_EN
    input  logic               mode_div,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result_s,
    output logic               last_s
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   add_s;
    logic [2*WIDTH:0] mul_cat_s;
    logic [WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0] step_shr_s;
`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   tmp_s;
    logic [WIDTH:0]   sub_s;
    logic             ge_s;
`endif

    // One iteration of the selected algorithm; {acc, shr} ends as product or {rem, quot}
    always_comb begin
        if (shr_q[0]) begin
            add_s = {1'b0, acc_q} + {1'b0, opb_q};
        end else begin
            add_s = {1'b0, acc_q};
        end
        mul_cat_s  = {add_s, shr_q};
        step_acc_s = mul_cat_s[2*WIDTH:WIDTH+1];
        step_shr_s = mul_cat_s[WIDTH:1];
`ifdef ALU_DIV_EN
        tmp_s = {acc_q, shr_q[WIDTH-1]};
        sub_s = tmp_s - {1'b0, opb_q};
        ge_s  = (tmp_s >= {1'b0, opb_q});
        if (div_q) begin
            if (ge_s) begin
                step_acc_s = sub_s[WIDTH-1:0];
            end else begin
                step_acc_s = tmp_s[WIDTH-1:0];
            end
            step_shr_s = {shr_q[WIDTH-2:0], ge_s};
        end else begin
            step_acc_s = mul_cat_s[2*WIDTH:WIDTH+1];
        end
`endif
        result_s = {step_acc_s, step_shr_s};
        last_s   = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state selection: load operands, advance one iteration, or hold
    always_comb begin
        acc_d = acc_q;
        shr_d = shr_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
`ifdef ALU_DIV_EN
        div_d = div_q;
`endif
        if (load) begin
            acc_d = {WIDTH{1'b0}};
            shr_d = a;
            opb_d = b;
            cnt_d = {CW{1'b0}};
`ifdef ALU_DIV_EN
            div_d = mode_div;
`endif
        end else if (step) begin
            acc_d = step_acc_s;
            shr_d = step_shr_s;
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {WIDTH{1'b0}};
            shr_q <= {WIDTH{1'b0}};
            opb_q <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_param.sv
// Fully registered WIDTH-bit ALU with a uniform Init/Done handshake.
// Define ALU_DIV_EN to compile in the iterative divider; otherwise DIV reports Err.
module alu_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_param_if.slave bus
);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] sal_q, sal_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               md_load_s;
    logic               md_step_s;
    logic               md_last_s;
    logic [2*WIDTH-1:0] md_result_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_load_s),
        .step     (md_step_s),
`ifdef ALU_DIV_EN
        .mode_div (bus.select == OP_DIV),
`endif
        .a        (bus.a),
        .b        (bus.b),
        .result_s (md_result_s),
        .last_s   (md_last_s)
    );

    // FSM next state, single-cycle results and completion of iterative ops
    always_comb begin
        state_d   = state_q;
        sal_d     = sal_q;
        cout_d    = cout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        md_load_s = 1'b0;
        md_step_s = 1'b0;
        sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_s    = {1'b0, bus.a} - {1'b0, bus.b};
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.init) begin
                    cout_d = 1'b0;
                    err_d  = 1'b0;
                    done_d = 1'b1;
                    case (bus.select)
                        OP_ADD: begin
                            sal_d  = {{(WIDTH-1){1'b0}}, sum_s};
                            cout_d = sum_s[WIDTH];
                        end
                        OP_SUB: begin
                            sal_d  = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
                            cout_d = diff_s[WIDTH];
                        end
                        OP_AND:    sal_d = {{WIDTH{1'b0}}, bus.a & bus.b};
                        OP_OR:     sal_d = {{WIDTH{1'b0}}, bus.a | bus.b};
                        OP_XOR:    sal_d = {{WIDTH{1'b0}}, bus.a ^ bus.b};
                        OP_PASS_A: sal_d = {{WIDTH{1'b0}}, bus.a};
                        OP_MUL: begin
                            md_load_s = 1'b1;
                            busy_d    = 1'b1;
                            done_d    = 1'b0;
                            state_d   = ST_RUN;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (bus.b == {WIDTH{1'b0}}) begin
                                sal_d = {bus.a, {WIDTH{1'b1}}};
                                err_d = 1'b1;
                            end else begin
                                md_load_s = 1'b1;
                                busy_d    = 1'b1;
                                done_d    = 1'b0;
                                state_d   = ST_RUN;
                            end
                        end
`endif
                        default: begin
                            sal_d = {(2*WIDTH){1'b0}};
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                md_step_s = 1'b1;
                if (md_last_s) begin
                    sal_d   = md_result_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sal_q   <= {(2*WIDTH){1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sal_q   <= sal_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.sal  = sal_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
